// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencing control. Selects the PC source
//                (NEXT / BRANCH / JUMP / JR), supplies the redirect operands,
//                buffers one redirect until the PC can advance, stalls fetch
//                on instruction/data memory waits and after halt, and counts
//                stall cycles with a saturating counter.
//  Ports       : CLK, nRST        clock, async active-low reset
//                ihit, dmem_req,  cache handshake inputs
//                dhit, halt
//                br_req/br_imm,   redirect requests and operands
//                j_req/j_addr,
//                jr_req/jr_tgt
//                pc_wait, PCSrc,  PC control outputs
//                load_imm, load_addr, jr_addr
//                flush, halted,   pipeline status outputs
//                stall_cnt
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             halt,
    input  logic             br_req,
    input  logic [15:0]      br_imm,
    input  logic             j_req,
    input  logic [25:0]      j_addr,
    input  logic             jr_req,
    input  logic [31:0]      jr_tgt,
    output logic             pc_wait,
    output logic [1:0]       PCSrc,
    output logic [15:0]      load_imm,
    output logic [25:0]      load_addr,
    output logic [31:0]      jr_addr,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REDIR  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [1:0] c_SRC_NEXT   = 2'd0;
    localparam logic [1:0] c_SRC_BRANCH = 2'd1;
    localparam logic [1:0] c_SRC_JUMP   = 2'd2;
    localparam logic [1:0] c_SRC_JR     = 2'd3;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_pend_sel;
    logic [15:0]      r_load_imm;
    logic [25:0]      r_load_addr;
    logic [31:0]      r_jr_addr;
    logic             r_flush;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_halted;
    logic             w_adv;
    logic             w_req;
    logic [1:0]       w_sel;
    logic             w_accept;

    assign w_halted = (r_state == ST_HALTED);
    assign w_adv    = ihit & ~(dmem_req & ~dhit) & ~w_halted & ~halt;
    assign w_req    = jr_req | j_req | br_req;
    assign w_sel    = jr_req ? c_SRC_JR : (j_req ? c_SRC_JUMP : c_SRC_BRANCH);

    // A redirect is accepted only from RUN; a simultaneous halt wins and
    // drops it, so no flush is produced for it.
    assign w_accept = (r_state == ST_RUN) & w_req & ~halt;

    assign pc_wait   = ~w_adv;
    assign halted    = w_halted;
    assign flush     = r_flush;
    assign stall_cnt = r_stall_cnt;

    // Next state and PC source selection. The held operand registers double
    // as the pending-redirect operand storage, so in REDIR (and in NEXT) the
    // operand outputs simply reflect them.
    always_comb begin
        w_state_nxt = r_state;
        PCSrc       = c_SRC_NEXT;
        load_imm    = r_load_imm;
        load_addr   = r_load_addr;
        jr_addr     = r_jr_addr;
        case (r_state)
            ST_RUN: begin
                if (halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_req) begin
                    PCSrc = w_sel;
                    case (w_sel)
                        c_SRC_BRANCH: load_imm  = br_imm;
                        c_SRC_JUMP:   load_addr = j_addr;
                        c_SRC_JR:     jr_addr   = jr_tgt;
                        default:      ;
                    endcase
                    if (!w_adv) begin
                        w_state_nxt = ST_REDIR;
                    end
                end
            end
            ST_REDIR: begin
                PCSrc = r_pend_sel;
                if (halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_adv) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending selector, held operands and flush pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pend_sel  <= c_SRC_NEXT;
            r_load_imm  <= 16'd0;
            r_load_addr <= 26'd0;
            r_jr_addr   <= 32'd0;
            r_flush     <= 1'b0;
        end else begin
            r_flush <= w_accept;
            if (w_accept) begin
                case (w_sel)
                    c_SRC_BRANCH: r_load_imm  <= br_imm;
                    c_SRC_JUMP:   r_load_addr <= j_addr;
                    c_SRC_JR:     r_jr_addr   <= jr_tgt;
                    default:      ;
                endcase
            end
            if (w_accept && !w_adv) begin
                r_pend_sel <= w_sel;
            end else if (w_state_nxt != ST_REDIR) begin
                r_pend_sel <= c_SRC_NEXT;
            end
        end
    end

    // Saturating stall counter; frozen once halted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (pc_wait && !w_halted && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
`default_nettype wire
